operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 11 +
 rtl/operand_fetch_fwd_mux.sv | 20 ++
 rtl/operand_fetch.sv | 101 ++++++++++
 tb/tb_operand_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared register-file widths, zero register and fetch FSM states
package operand_fetch_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ALUOP_W = 8;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [ALUOP_W-1:0] aluop_t;
  localparam reg_addr_t ZERO_REG = '0;
  typedef enum logic {RUN, BUBBLE} state_t;
endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// fwd_mux: resolves one source operand from zero register, EX/MEM bypass or regfile
module fwd_mux import operand_fetch_pkg::*; (
  input  logic      en,
  input  reg_addr_t addr,
  input  reg_data_t rdata,
  input  logic      ex_wreg,
  input  logic      ex_is_load,
  input  reg_addr_t ex_wd,
  input  reg_data_t ex_wdata,
  input  logic      mem_wreg,
  input  reg_addr_t mem_wd,
  input  reg_data_t mem_wdata,
  output reg_data_t data
);
  always_comb begin
    data = (!en || addr == ZERO_REG) ? '0 :
           (ex_wreg && !ex_is_load && ex_wd == addr) ? ex_wdata :
           (mem_wreg && mem_wd == addr) ? mem_wdata : rdata;
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: regfile read, operand bypass, load-use stall and ID/EX register
module operand_fetch import operand_fetch_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      id_valid,
  input  logic      id_rs_en,
  input  logic      id_rt_en,
  input  reg_addr_t id_rs_addr,
  input  reg_addr_t id_rt_addr,
  input  reg_addr_t id_wd,
  input  logic      id_wreg,
  input  aluop_t    id_aluop,
  input  logic      id_is_load,
  output logic      id_ready,
  output logic      re1,
  output reg_addr_t raddr1,
  output logic      re2,
  output reg_addr_t raddr2,
  input  reg_data_t rdata1,
  input  reg_data_t rdata2,
  input  logic      ex_fwd_wreg,
  input  reg_addr_t ex_fwd_wd,
  input  reg_data_t ex_fwd_wdata,
  input  logic      ex_fwd_is_load,
  input  logic      mem_fwd_wreg,
  input  reg_addr_t mem_fwd_wd,
  input  reg_data_t mem_fwd_wdata,
  input  logic      flush,
  input  logic      ex_ready,
  output logic      ex_valid,
  output reg_data_t ex_reg1,
  output reg_data_t ex_reg2,
  output reg_addr_t ex_wd,
  output logic      ex_wreg,
  output aluop_t    ex_aluop,
  output logic      ex_is_load,
  output logic [15:0] stall_cnt
);
  state_t state, state_nx;
  reg_data_t op1, op2;
  logic hazard;
  assign re1 = id_valid & id_rs_en;
  assign raddr1 = id_rs_addr;
  assign re2 = id_valid & id_rt_en;
  assign raddr2 = id_rt_addr;
  fwd_mux u_rs (
    .en(re1), .addr(id_rs_addr), .rdata(rdata1),
    .ex_wreg(ex_fwd_wreg), .ex_is_load(ex_fwd_is_load), .ex_wd(ex_fwd_wd), .ex_wdata(ex_fwd_wdata),
    .mem_wreg(mem_fwd_wreg), .mem_wd(mem_fwd_wd), .mem_wdata(mem_fwd_wdata), .data(op1)
  );
  fwd_mux u_rt (
    .en(re2), .addr(id_rt_addr), .rdata(rdata2),
    .ex_wreg(ex_fwd_wreg), .ex_is_load(ex_fwd_is_load), .ex_wd(ex_fwd_wd), .ex_wdata(ex_fwd_wdata),
    .mem_wreg(mem_fwd_wreg), .mem_wd(mem_fwd_wd), .mem_wdata(mem_fwd_wdata), .data(op2)
  );
  // a load in EX has no data yet, so a dependent instruction must wait one cycle
  always_comb begin
    hazard = ex_fwd_wreg & ex_fwd_is_load & (ex_fwd_wd != ZERO_REG) & id_valid &
             ((re1 & (id_rs_addr == ex_fwd_wd)) | (re2 & (id_rt_addr == ex_fwd_wd)));
    id_ready = ex_ready & ~hazard & ~flush;
    state_nx = (state == RUN && hazard && ex_ready && !flush) ? BUBBLE : RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      ex_valid <= 1'b0;
      ex_reg1 <= '0;
      ex_reg2 <= '0;
      ex_wd <= '0;
      ex_wreg <= 1'b0;
      ex_aluop <= '0;
      ex_is_load <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        ex_valid <= 1'b0;
        ex_reg1 <= '0;
        ex_reg2 <= '0;
        ex_wd <= '0;
        ex_wreg <= 1'b0;
        ex_aluop <= '0;
        ex_is_load <= 1'b0;
      end else if (ex_ready) begin
        if (hazard) begin
          ex_valid <= 1'b0;
          ex_wreg <= 1'b0;
          if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end else begin
          ex_valid <= id_valid;
          ex_reg1 <= op1;
          ex_reg2 <= op2;
          ex_wd <= id_wd;
          ex_wreg <= id_valid & id_wreg;
          ex_aluop <= id_aluop;
          ex_is_load <= id_is_load;
        end
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: random and directed stimulus scored against a behavioural pipeline-stage model
module tb_operand_fetch;
  import operand_fetch_pkg::*;
  typedef struct packed {
    logic v, rs_en, rt_en;
    logic [4:0] rs, rt, wd;
    logic wreg;
    logic [7:0] aluop;
    logic is_load;
    logic exw;
    logic [4:0] exwd;
    logic [31:0] exd;
    logic exl;
    logic memw;
    logic [4:0] memwd;
    logic [31:0] memd;
    logic flush, ex_ready;
  } stim_t;
  typedef struct packed {
    logic v;
    logic [31:0] r1, r2;
    logic [4:0] wd;
    logic wreg;
    logic [7:0] aluop;
    logic is_load;
    logic [15:0] stall;
    logic bub;
  } exp_t;
  logic clk = 0, rst = 0;
  logic id_valid, id_rs_en, id_rt_en, id_wreg, id_is_load, id_ready;
  logic [4:0] id_rs_addr, id_rt_addr, id_wd, raddr1, raddr2, ex_fwd_wd, mem_fwd_wd, ex_wd;
  logic [7:0] id_aluop, ex_aluop;
  logic re1, re2, ex_fwd_wreg, ex_fwd_is_load, mem_fwd_wreg, flush, ex_ready;
  logic [31:0] rdata1, rdata2, ex_fwd_wdata, mem_fwd_wdata, ex_reg1, ex_reg2;
  logic ex_valid, ex_wreg, ex_is_load;
  logic [15:0] stall_cnt;
  logic [31:0] rf [32];
  int checks = 0, errors = 0;
  exp_t m = '0;
  exp_t q[$];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];
  always #5 clk = ~clk;
  operand_fetch dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wd(id_wd), .id_wreg(id_wreg),
    .id_aluop(id_aluop), .id_is_load(id_is_load), .id_ready(id_ready),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .ex_fwd_wreg(ex_fwd_wreg), .ex_fwd_wd(ex_fwd_wd), .ex_fwd_wdata(ex_fwd_wdata), .ex_fwd_is_load(ex_fwd_is_load),
    .mem_fwd_wreg(mem_fwd_wreg), .mem_fwd_wd(mem_fwd_wd), .mem_fwd_wdata(mem_fwd_wdata),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_aluop(ex_aluop), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] operand(input logic en, input logic [4:0] a, input stim_t s);
    if (!en || a == 0) return 0;
    if (s.exw && !s.exl && s.exwd == a) return s.exd;
    if (s.memw && s.memwd == a) return s.memd;
    return rf[a];
  endfunction
  function automatic stim_t idle();
    stim_t s = '0;
    s.ex_ready = 1;
    return s;
  endfunction
  function automatic stim_t instr(input logic [4:0] rs, input logic [4:0] rt);
    stim_t s = idle();
    s.v = 1; s.rs_en = 1; s.rt_en = 1; s.rs = rs; s.rt = rt;
    s.wd = 5'd9; s.wreg = 1; s.aluop = 8'h21;
    return s;
  endfunction
  task automatic drive(input stim_t s);
    logic e1, e2, hz, nb;
    @(negedge clk);
    id_valid = s.v; id_rs_en = s.rs_en; id_rt_en = s.rt_en; id_rs_addr = s.rs; id_rt_addr = s.rt;
    id_wd = s.wd; id_wreg = s.wreg; id_aluop = s.aluop; id_is_load = s.is_load;
    ex_fwd_wreg = s.exw; ex_fwd_wd = s.exwd; ex_fwd_wdata = s.exd; ex_fwd_is_load = s.exl;
    mem_fwd_wreg = s.memw; mem_fwd_wd = s.memwd; mem_fwd_wdata = s.memd;
    flush = s.flush; ex_ready = s.ex_ready;
    #1;
    e1 = s.v & s.rs_en;
    e2 = s.v & s.rt_en;
    hz = s.exw && s.exl && s.exwd != 0 && s.v && ((e1 && s.rs == s.exwd) || (e2 && s.rt == s.exwd));
    chk("re1", {31'b0, re1}, {31'b0, e1});
    chk("re2", {31'b0, re2}, {31'b0, e2});
    chk("raddr1", {27'b0, raddr1}, {27'b0, s.rs});
    chk("raddr2", {27'b0, raddr2}, {27'b0, s.rt});
    chk("id_ready", {31'b0, id_ready}, {31'b0, s.ex_ready && !hz && !s.flush});
    nb = !m.bub && hz && s.ex_ready && !s.flush;
    if (!rst) m = '0;
    else if (s.flush) begin
      m = '{v: 0, r1: 0, r2: 0, wd: 0, wreg: 0, aluop: 0, is_load: 0, stall: m.stall, bub: 0};
    end else if (s.ex_ready) begin
      if (hz) begin
        m.v = 0; m.wreg = 0;
        m.stall = (m.stall == 16'hFFFF) ? m.stall : m.stall + 1;
      end else begin
        m.v = s.v; m.r1 = operand(e1, s.rs, s); m.r2 = operand(e2, s.rt, s);
        m.wd = s.wd; m.wreg = s.v & s.wreg; m.aluop = s.aluop; m.is_load = s.is_load;
      end
      m.bub = nb;
    end else m.bub = 0;
    q.push_back(m);
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.v});
      chk("ex_reg1", ex_reg1, e.r1);
      chk("ex_reg2", ex_reg2, e.r2);
      chk("ex_wd", {27'b0, ex_wd}, {27'b0, e.wd});
      chk("ex_wreg", {31'b0, ex_wreg}, {31'b0, e.wreg});
      chk("ex_aluop", {24'b0, ex_aluop}, {24'b0, e.aluop});
      chk("ex_is_load", {31'b0, ex_is_load}, {31'b0, e.is_load});
      chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, e.stall});
      chk("fsm_bubble", {31'b0, dut.state == BUBBLE}, {31'b0, e.bub});
    end
  end
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask
  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, {31'b0, ex_valid}, 0);
    chk({tag, "_reg1"}, ex_reg1, 0);
    chk({tag, "_reg2"}, ex_reg2, 0);
    chk({tag, "_wreg"}, {31'b0, ex_wreg}, 0);
    chk({tag, "_stall"}, {16'b0, stall_cnt}, 0);
    chk({tag, "_fsm"}, {31'b0, dut.state == BUBBLE}, 0);
  endtask
  initial begin
    stim_t s;
    logic [15:0] st0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[3] = 32'h3333; rf[4] = 32'h4444;
    s = idle();
    #2;
    check_cleared("reset");
    drive(s);
    drive(s);
    rst = 1;
    s = instr(5'd3, 5'd4);
    drive(s);
    after_edge();
    chk("plain_valid", {31'b0, ex_valid}, 1);
    chk("plain_reg1", ex_reg1, 32'h3333);
    chk("plain_reg2", ex_reg2, 32'h4444);
    s = instr(5'd5, 5'd4);
    s.exw = 1; s.exwd = 5; s.exd = 32'hAAAA; s.memw = 1; s.memwd = 5; s.memd = 32'hBBBB;
    drive(s);
    after_edge();
    chk("fwd_ex_wins", ex_reg1, 32'hAAAA);
    s.exwd = 6;
    drive(s);
    after_edge();
    chk("fwd_mem", ex_reg1, 32'hBBBB);
    s.rs = 0; s.exwd = 0; s.memwd = 0;
    drive(s);
    after_edge();
    chk("fwd_zero_reg", ex_reg1, 0);
    s = instr(5'd7, 5'd4);
    s.exw = 1; s.exl = 1; s.exwd = 7; s.exd = 32'hDEAD;
    drive(s);
    after_edge();
    chk("loaduse_bubble", {31'b0, ex_valid}, 0);
    chk("loaduse_stall", {16'b0, stall_cnt}, 1);
    s = instr(5'd7, 5'd4);
    s.memw = 1; s.memwd = 7; s.memd = 32'h5678;
    drive(s);
    after_edge();
    chk("loaduse_mem", ex_reg1, 32'h5678);
    s = instr(5'd3, 5'd2);
    s.aluop = 8'h5A;
    drive(s);
    s = instr(5'd4, 5'd3);
    s.ex_ready = 0;
    for (int i = 0; i < 3; i++) drive(s);
    after_edge();
    chk("bp_frozen", ex_reg1, 32'h3333);
    s.ex_ready = 1;
    drive(s);
    drive(idle());
    after_edge();
    chk("bp_once", {31'b0, ex_valid}, 0);
    st0 = stall_cnt;
    s = instr(5'd7, 5'd4);
    s.exw = 1; s.exl = 1; s.exwd = 7; s.flush = 1;
    drive(s);
    after_edge();
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_stall", {16'b0, stall_cnt}, {16'b0, st0});
    chk("flush_fsm", {31'b0, dut.state == BUBBLE}, 0);
    for (int n = 0; n < 600; n++) begin
      s.v = ($urandom % 4) != 0; s.rs_en = $urandom; s.rt_en = $urandom;
      s.rs = 5'($urandom % 8); s.rt = 5'($urandom % 8); s.wd = 5'($urandom);
      s.wreg = $urandom; s.aluop = 8'($urandom); s.is_load = $urandom;
      s.exw = $urandom; s.exwd = 5'($urandom % 8); s.exd = $urandom; s.exl = ($urandom % 3) == 0;
      s.memw = $urandom; s.memwd = 5'($urandom % 8); s.memd = $urandom;
      s.flush = ($urandom % 10) == 0; s.ex_ready = ($urandom % 5) != 0;
      drive(s);
      if (n == 300) begin
        #2;
        rst = 0;
        #1;
        q.delete();
        m = '0;
        check_cleared("async_rst");
        drive(s);
        rst = 1;
        s = instr(5'd3, 5'd4);
        drive(s);
        after_edge();
        chk("post_rst_latency", {31'b0, ex_valid}, 1);
        chk("post_rst_reg1", ex_reg1, 32'h3333);
      end
    end
    drive(idle());
    after_edge();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
